prim_reqack_bridge: RTL and testbench



---
 rtl/prim_reqack_bridge_pkg.sv | 22 ++
 rtl/prim_reqack_bridge_ch.sv | 143 ++++++++++++++
 rtl/prim_reqack_bridge.sv | 42 ++++
 tb/tb_prim_reqack_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_reqack_bridge_pkg.sv
// Shared state type and width helper for the REQ/ACK to link handshake bridge.
package prim_reqack_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RETURN = 2'd2,
        ERR    = 2'd3
    } bridge_state_e;

    // Timeout counter width; a disabled timeout still needs a 1-bit vector.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        if (cycles == 0) begin
            w = 1;
        end else begin
            w = unsigned'($clog2(cycles + 1));
        end
        return w;
    endfunction

endpackage

// File: rtl/prim_reqack_bridge_ch.sv
// One bridge channel: master REQ/ACK towards an NRZ or RZ link handshake,
// with wait timeout, spurious-ACK detection and clear-driven recovery.
//
// state  | meaning
// IDLE   | no transaction; NRZ: link phases must agree
// WAIT   | link_req issued, waiting for the link ACK
// RETURN | RZ only: link_req dropped, waiting for link ACK to fall
// ERR    | timeout or spurious ACK; frozen until clr_err
module prim_reqack_bridge_ch
    import prim_reqack_bridge_pkg::*;
#(
    parameter bit          EnRzHs        = 1'b0,
    parameter int unsigned TimeoutCycles = 255,
    parameter int unsigned CntW          = cnt_width(TimeoutCycles)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    output logic ack_o,
    output logic link_req_o,
    input  logic link_ack_i,
    output logic busy_o,
    output logic timeout_o,
    output logic proto_err_o,
    input  logic clr_err_i
);

    localparam bit              TmoEn   = (TimeoutCycles != 0);
    localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] TmoMax  = CntW'(TimeoutCycles);

    bridge_state_e   state_q, state_d;
    logic            link_req_q, link_req_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            perr_q, perr_d;

    logic waiting;
    logic link_match;
    logic timeout_hit;
    logic ack_fire;

    assign waiting     = (state_q == WAIT) || (state_q == RETURN);
    assign link_match  = EnRzHs ? link_ack_i : (link_ack_i == link_req_q);
    // The TimeoutCycles-th waiting cycle expires the wait, ahead of any ACK.
    assign timeout_hit = TmoEn && waiting && (cnt_q == TmoLast);
    assign ack_fire    = (state_q == WAIT) && link_match && !timeout_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            link_req_q <= 1'b0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            link_req_q <= link_req_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        link_req_d = link_req_q;
        timeout_d  = timeout_q;
        perr_d     = perr_q;
        unique case (state_q)
            IDLE: begin
                if (!EnRzHs && (link_ack_i != link_req_q)) begin
                    perr_d  = 1'b1;
                    state_d = ERR;
                end else if (req_i && !(EnRzHs && link_ack_i)) begin
                    link_req_d = EnRzHs ? 1'b1 : ~link_req_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ERR;
                end else if (link_match) begin
                    if (EnRzHs) begin
                        link_req_d = 1'b0;
                        state_d    = RETURN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RETURN: begin
                if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ERR;
                end else if (!link_ack_i) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (clr_err_i) begin
                    timeout_d = 1'b0;
                    perr_d    = 1'b0;
                    if (EnRzHs) begin
                        link_req_d = 1'b0;
                        state_d    = RETURN;
                    end else begin
                        // Abandon the transaction and adopt the peer's phase.
                        link_req_d = link_ack_i;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q;
        if (!TmoEn || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != TmoMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        ack_o       = ack_fire && !rst_i;
        busy_o      = (state_q != IDLE) && !rst_i;
        link_req_o  = link_req_q;
        timeout_o   = timeout_q;
        proto_err_o = perr_q;
    end

`ifdef INC_ASSERT
    a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_i && !ack_o && (state_q == WAIT)) |=> req_i);
    a_ack_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
        ack_o |=> !ack_o);
    a_ack_req: assert property (@(posedge clk_i) disable iff (rst_i)
        ack_o |-> req_i);
`endif

endmodule

// File: rtl/prim_reqack_bridge.sv
// Multi-channel REQ/ACK to link handshake bridge; channels are independent.
module prim_reqack_bridge
    import prim_reqack_bridge_pkg::*;
#(
    parameter int unsigned NumCh         = 4,
    parameter bit          EnRzHs        = 1'b0,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumCh-1:0] req_i,
    output logic [NumCh-1:0] ack_o,
    output logic [NumCh-1:0] link_req_o,
    input  logic [NumCh-1:0] link_ack_i,
    output logic [NumCh-1:0] busy_o,
    output logic [NumCh-1:0] timeout_o,
    output logic [NumCh-1:0] proto_err_o,
    input  logic [NumCh-1:0] clr_err_i
);

    localparam int unsigned CntW = cnt_width(TimeoutCycles);

    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        prim_reqack_bridge_ch #(
            .EnRzHs       (EnRzHs),
            .TimeoutCycles(TimeoutCycles),
            .CntW         (CntW)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .req_i      (req_i[g]),
            .ack_o      (ack_o[g]),
            .link_req_o (link_req_o[g]),
            .link_ack_i (link_ack_i[g]),
            .busy_o     (busy_o[g]),
            .timeout_o  (timeout_o[g]),
            .proto_err_o(proto_err_o[g]),
            .clr_err_i  (clr_err_i[g])
        );
    end

endmodule

// File: tb/tb_prim_reqack_bridge.sv
// Randomised bench for prim_reqack_bridge: three configurations driven by a
// random master and link peer, outputs scored against a protocol-level model.
module tb_prim_reqack_bridge;

    localparam int NI   = 3;
    localparam int NC   = 4;
    localparam int NCYC = 6000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s;
    logic [3:0] req_s  [NI];
    logic [3:0] ack_s  [NI];
    logic [3:0] lreq_s [NI];
    logic [3:0] lack_s [NI];
    logic [3:0] busy_s [NI];
    logic [3:0] tmo_s  [NI];
    logic [3:0] perr_s [NI];
    logic [3:0] clr_s  [NI];

    prim_reqack_bridge #(.NumCh(4), .EnRzHs(1'b0), .TimeoutCycles(8)) dut_nrz (
        .clk_i(clk), .rst_i(rst_s), .req_i(req_s[0]), .ack_o(ack_s[0]),
        .link_req_o(lreq_s[0]), .link_ack_i(lack_s[0]), .busy_o(busy_s[0]),
        .timeout_o(tmo_s[0]), .proto_err_o(perr_s[0]), .clr_err_i(clr_s[0]));

    prim_reqack_bridge #(.NumCh(4), .EnRzHs(1'b1), .TimeoutCycles(6)) dut_rz (
        .clk_i(clk), .rst_i(rst_s), .req_i(req_s[1]), .ack_o(ack_s[1]),
        .link_req_o(lreq_s[1]), .link_ack_i(lack_s[1]), .busy_o(busy_s[1]),
        .timeout_o(tmo_s[1]), .proto_err_o(perr_s[1]), .clr_err_i(clr_s[1]));

    prim_reqack_bridge #(.NumCh(4), .EnRzHs(1'b0), .TimeoutCycles(0)) dut_notmo (
        .clk_i(clk), .rst_i(rst_s), .req_i(req_s[2]), .ack_o(ack_s[2]),
        .link_req_o(lreq_s[2]), .link_ack_i(lack_s[2]), .busy_o(busy_s[2]),
        .timeout_o(tmo_s[2]), .proto_err_o(perr_s[2]), .clr_err_i(clr_s[2]));

    typedef struct {
        int         k;
        int         cyc;
        logic [3:0] ack;
        logic [3:0] lreq;
        logic [3:0] busy;
        logic [3:0] tmo;
        logic [3:0] perr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Model phases: 0 idle, 1 awaiting ACK, 2 awaiting ACK release (RZ), 3 error.
    int m_ph    [NI][NC];
    int m_n     [NI][NC];
    bit m_lreq  [NI][NC];
    bit m_tmo   [NI][NC];
    bit m_perr  [NI][NC];
    bit p_ack   [NI][NC];
    int p_cnt   [NI][NC];
    bit i_req   [NI][NC];
    bit i_clr   [NI][NC];
    bit last_ack[NI][NC];
    bit i_rst;

    function automatic bit cfg_rz(input int k);
        return (k == 1);
    endfunction

    function automatic int cfg_to(input int k);
        if (k == 0) return 8;
        if (k == 1) return 6;
        return 0;
    endfunction

    function automatic bit model_timed(input int k, input int c);
        return (cfg_to(k) > 0) && (m_ph[k][c] == 1 || m_ph[k][c] == 2)
               && (m_n[k][c] == cfg_to(k));
    endfunction

    function automatic bit model_match(input int k, input int c);
        if (cfg_rz(k)) return p_ack[k][c];
        return p_ack[k][c] == m_lreq[k][c];
    endfunction

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < NC; c++) begin
                int nxt;
                bit tm;
                bit mt;
                bit rz;
                nxt = m_ph[k][c];
                tm  = model_timed(k, c);
                mt  = model_match(k, c);
                rz  = cfg_rz(k);
                if (i_rst) begin
                    m_ph[k][c]   = 0;
                    m_n[k][c]    = 1;
                    m_lreq[k][c] = 1'b0;
                    m_tmo[k][c]  = 1'b0;
                    m_perr[k][c] = 1'b0;
                    p_ack[k][c]  = 1'b0;
                    p_cnt[k][c]  = -1;
                end else begin
                    case (m_ph[k][c])
                        0: begin
                            if (!rz && p_ack[k][c] != m_lreq[k][c]) begin
                                m_perr[k][c] = 1'b1;
                                nxt = 3;
                            end else if (i_req[k][c] && !(rz && p_ack[k][c])) begin
                                m_lreq[k][c] = rz ? 1'b1 : !m_lreq[k][c];
                                nxt = 1;
                            end
                        end
                        1: begin
                            if (tm) begin
                                m_tmo[k][c] = 1'b1;
                                nxt = 3;
                            end else if (mt) begin
                                nxt = rz ? 2 : 0;
                                if (rz) m_lreq[k][c] = 1'b0;
                            end
                        end
                        2: begin
                            if (tm) begin
                                m_tmo[k][c] = 1'b1;
                                nxt = 3;
                            end else if (!p_ack[k][c]) begin
                                nxt = 0;
                            end
                        end
                        default: begin
                            if (i_clr[k][c]) begin
                                m_tmo[k][c]  = 1'b0;
                                m_perr[k][c] = 1'b0;
                                m_lreq[k][c] = rz ? 1'b0 : p_ack[k][c];
                                nxt = rz ? 2 : 0;
                            end
                        end
                    endcase
                    m_n[k][c]  = (nxt == m_ph[k][c]) ? m_n[k][c] + 1 : 1;
                    m_ph[k][c] = nxt;
                end
            end
        end
    endtask

    task automatic pick_inputs(input int cyc);
        i_rst = (cyc < 3) || ($urandom_range(0, 399) == 0);
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < NC; c++) begin
                // Link peer follows link_req after a random delay; rarely glitches.
                if (p_ack[k][c] == m_lreq[k][c]) begin
                    p_cnt[k][c] = -1;
                    if ($urandom_range(0, 149) == 0) p_ack[k][c] = !p_ack[k][c];
                end else if (p_cnt[k][c] < 0) begin
                    p_cnt[k][c] = int'($urandom_range(0, 10));
                end else if (p_cnt[k][c] == 0) begin
                    p_ack[k][c] = m_lreq[k][c];
                end else begin
                    p_cnt[k][c] = p_cnt[k][c] - 1;
                end

                if (last_ack[k][c]) begin
                    i_req[k][c] = ($urandom_range(0, 1) == 1);
                end else begin
                    case (m_ph[k][c])
                        0: if (!i_req[k][c]) i_req[k][c] = ($urandom_range(0, 2) == 0);
                        1: if ($urandom_range(0, 39) == 0) i_req[k][c] = 1'b0;
                        3: if ($urandom_range(0, 7) == 0) i_req[k][c] = 1'b0;
                        default: ;
                    endcase
                end

                if (m_ph[k][c] == 3) i_clr[k][c] = ($urandom_range(0, 4) == 0);
                else                 i_clr[k][c] = ($urandom_range(0, 29) == 0);
            end
        end
    endtask

    task automatic drive();
        rst_s = i_rst;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < NC; c++) begin
                req_s[k][c]  = i_req[k][c];
                lack_s[k][c] = p_ack[k][c];
                clr_s[k][c]  = i_clr[k][c];
            end
        end
    endtask

    task automatic push_expected(input int cyc);
        for (int k = 0; k < NI; k++) begin
            exp_t e;
            e.k   = k;
            e.cyc = cyc;
            for (int c = 0; c < NC; c++) begin
                bit a;
                a = !i_rst && (m_ph[k][c] == 1) && model_match(k, c) && !model_timed(k, c);
                last_ack[k][c] = a;
                e.ack[c]  = a;
                e.busy[c] = !i_rst && (m_ph[k][c] != 0);
                e.lreq[c] = m_lreq[k][c];
                e.tmo[c]  = m_tmo[k][c];
                e.perr[c] = m_perr[k][c];
            end
            sb.push_back(e);
        end
    endtask

    task automatic compare(input string name, input int k, input int cyc,
                           input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d cycle %0d: got %b expected %b", name, k, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                compare("ack_o",       e.k, e.cyc, ack_s[e.k],  e.ack);
                compare("link_req_o",  e.k, e.cyc, lreq_s[e.k], e.lreq);
                compare("busy_o",      e.k, e.cyc, busy_s[e.k], e.busy);
                compare("timeout_o",   e.k, e.cyc, tmo_s[e.k],  e.tmo);
                compare("proto_err_o", e.k, e.cyc, perr_s[e.k], e.perr);
            end
        end
    end

    initial begin
        i_rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < NC; c++) begin
                m_ph[k][c]     = 0;
                m_n[k][c]      = 1;
                m_lreq[k][c]   = 1'b0;
                m_tmo[k][c]    = 1'b0;
                m_perr[k][c]   = 1'b0;
                p_ack[k][c]    = 1'b0;
                p_cnt[k][c]    = -1;
                i_req[k][c]    = 1'b0;
                i_clr[k][c]    = 1'b0;
                last_ack[k][c] = 1'b0;
            end
        end
        drive();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            model_step();
            pick_inputs(cyc);
            #1;
            drive();
            push_expected(cyc);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
